pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source.
REQ-005 ex_rd, mem_rd, wb_rd  in  5 each  destination registers in EX, MEM and WB.
REQ-006 ex_wen, mem_wen, wb_wen  in  1 each  register-file write enables of those stages.
REQ-007 ex_is_load  in  1  EX instruction is a load.
REQ-008 br_taken  in  1  EX resolves a taken branch or jump, so the PC is redirected.
REQ-009 dmem_req, dmem_ready  in  1 each  MEM-stage data access pending, and data memory ready.
REQ-010 pc_en, ifid_en, idex_en, exmem_en  out  1 each  pipeline register enables.
REQ-011 ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX.
REQ-012 fwd_rs1_sel, fwd_rs2_sel  out  2 each  operand source: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB data.
REQ-013 state  out  2  registered controller state.
REQ-014 stall_cycles, flush_count  out  16 each  saturating performance counters.
REQ-015 mem_timeout  out  1  sticky data-memory timeout error.

Function
REQ-016 All enable, flush and select outputs SHALL be combinational from the current inputs, with zero latency.
REQ-017 Decisions SHALL be prioritised in this order: MEM_WAIT, then FLUSH, then HAZARD, then RUN.
- Rule: a "match" on a stage means id_use_rsN=1, rsN!=0, the stage write enable is 1, and the stage rd equals rsN.
REQ-018 MEM_WAIT (dmem_req=1 and dmem_ready=0) SHALL drive all four enables to 0 and both flushes to 0.
- A br_taken raised during the wait SHALL be held, not acted on.
REQ-019 FLUSH (br_taken=1, no MEM_WAIT) SHALL drive:
- pc_en=1, ifid_flush=1, idex_flush=1, all other enables 1;
- any concurrent hazard SHALL be ignored.
REQ-020 HAZARD with FWD_EN defined: ex_is_load=1 and an EX match on either source.
REQ-021 HAZARD response SHALL be pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, giving exactly one bubble.
REQ-022 Forwarding select, per source:
- priority EX(1) > MEM(2) > WB(3) > regfile(0);
- an EX match on a load SHALL NOT select 1;
- register x0 SHALL always select 0.
REQ-023 In any cycle with no MEM_WAIT, FLUSH or HAZARD (RUN), all enables SHALL be 1 and both flushes 0.
REQ-024 state SHALL register the decision taken each cycle:
- RUN = 00, HAZARD = 01, MEM_WAIT = 10, FLUSH = 11.
REQ-025 stall_cycles SHALL increment once per HAZARD or MEM_WAIT cycle and saturate at 0xFFFF.
REQ-026 flush_count SHALL increment once per FLUSH cycle and saturate at 0xFFFF.
REQ-027 An internal 8-bit wait counter SHALL behave as follows:
- increments in each MEM_WAIT cycle;
- clears in any non-MEM_WAIT cycle;
- on reaching 255 it SHALL set mem_timeout, which stays 1 until reset.
REQ-028 MEM_WAIT SHALL still freeze the pipeline after mem_timeout is set.

Reset
REQ-029 When rst=0, the following SHALL clear immediately, independent of clk:
- state = 00, stall_cycles = 0, flush_count = 0, wait counter = 0, mem_timeout = 0.
REQ-030 Combinational outputs SHALL follow REQ-016..023 while rst=0.
- An assertion mid-stall SHALL abandon the stall with no residual effect after release.

Configuration
REQ-031 Macro FWD_EN, when defined, SHALL enable forwarding per REQ-020 and REQ-022.
REQ-032 When FWD_EN is not defined:
- fwd_rs1_sel and fwd_rs2_sel SHALL be constant 0;
- HAZARD SHALL be any EX, MEM or WB match, load or not;
- HAZARD SHALL hold each cycle until no match remains.

Verification
REQ-033 Scenario, FWD_EN: ex_rd=5, ex_wen=1, ex_is_load=0, id_rs1=5 -> fwd_rs1_sel=1, no stall, state next=00.
REQ-034 Scenario, FWD_EN: load into x5 in EX, id_rs2=5 used -> one cycle with pc_en=0 and idex_flush=1, state=01; next cycle fwd_rs2_sel=2.
REQ-035 Scenario: br_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1, flush_count increments by 1, state=11.
REQ-036 Scenario: dmem_req=1, dmem_ready=0 held for 300 cycles with br_taken=1 -> all enables 0 and no flush; mem_timeout rises after the 255th wait cycle; stall_cycles=300.
REQ-037 Scenario, no FWD_EN: wb_rd=3, wb_wen=1, id_rs1=3 -> stall, select 0; id_rs1=0 with ex_rd=0, ex_wen=1 -> no stall.
REQ-038 Scenario: rst pulsed low asynchronously mid-MEM_WAIT -> state=00, counters=0, mem_timeout=0 before the next clk edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/stall controller with forwarding selects and perf counters.
// Optional operand forwarding is enabled by defining FWD_EN.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic        ex_wen,
   input  logic        mem_wen,
   input  logic        wb_wen,
   input  logic        ex_is_load,
   input  logic        br_taken,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic [1:0]  fwd_rs1_sel,
   output logic [1:0]  fwd_rs2_sel,
   output logic [1:0]  state,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count,
   output logic        mem_timeout
);

   // state     | meaning
   // ST_RUN    | normal advance, no hazard
   // ST_HAZARD | one bubble inserted into ID/EX, front end held
   // ST_MEM_WAIT | data memory not ready, whole pipe frozen
   // ST_FLUSH  | taken branch, IF/ID and ID/EX squashed
   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_HAZARD   = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_FLUSH    = 2'b11
   } state_t;

   state_t     state_q;
   state_t     decision;
   logic [7:0] wait_cnt;
   logic       hazard;

   function automatic logic hit(input logic use_rs, input logic [4:0] rs,
                                input logic [4:0] rd, input logic wen);
      return use_rs && (rs != 5'd0) && wen && (rd == rs);
   endfunction

   logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
   assign ex_m1  = hit(id_use_rs1, id_rs1, ex_rd,  ex_wen);
   assign ex_m2  = hit(id_use_rs2, id_rs2, ex_rd,  ex_wen);
   assign mem_m1 = hit(id_use_rs1, id_rs1, mem_rd, mem_wen);
   assign mem_m2 = hit(id_use_rs2, id_rs2, mem_rd, mem_wen);
   assign wb_m1  = hit(id_use_rs1, id_rs1, wb_rd,  wb_wen);
   assign wb_m2  = hit(id_use_rs2, id_rs2, wb_rd,  wb_wen);

`ifdef FWD_EN
   // A load result is not available in EX, so it never forwards from there.
   function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                          input logic wb_m, input logic is_load);
      if (ex_m && !is_load) return 2'd1;
      else if (mem_m)       return 2'd2;
      else if (wb_m)        return 2'd3;
      else                  return 2'd0;
   endfunction

   assign hazard      = ex_is_load && (ex_m1 || ex_m2);
   assign fwd_rs1_sel = fwd_sel(ex_m1, mem_m1, wb_m1, ex_is_load);
   assign fwd_rs2_sel = fwd_sel(ex_m2, mem_m2, wb_m2, ex_is_load);
`else
   assign hazard      = ex_m1 || ex_m2 || mem_m1 || mem_m2 || wb_m1 || wb_m2;
   assign fwd_rs1_sel = 2'd0;
   assign fwd_rs2_sel = 2'd0;
`endif

   always_comb begin
      decision   = ST_RUN;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (dmem_req && !dmem_ready) begin
         decision = ST_MEM_WAIT;
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (br_taken) begin
         decision   = ST_FLUSH;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard) begin
         decision   = ST_HAZARD;
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         stall_cycles <= 16'd0;
         flush_count  <= 16'd0;
         wait_cnt     <= 8'd0;
         mem_timeout  <= 1'b0;
      end else begin
         state_q <= decision;
         if ((decision == ST_HAZARD || decision == ST_MEM_WAIT) && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
         if (decision == ST_FLUSH && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
         if (decision == ST_MEM_WAIT) begin
            if (wait_cnt != 8'hFF)
               wait_cnt <= wait_cnt + 8'd1;
            // Counter reaches 255 on this edge.
            if (wait_cnt == 8'hFE)
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= 8'd0;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; FWD_EN scenarios run only when the macro is defined.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_use_rs1, id_use_rs2, ex_wen, mem_wen, wb_wen;
   logic        ex_is_load, br_taken, dmem_req, dmem_ready;
   logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
   logic [1:0]  fwd_rs1_sel, fwd_rs2_sel, state;
   logic [15:0] stall_cycles, flush_count;
   logic        mem_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
      .ex_is_load(ex_is_load), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
      .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
   localparam logic [5:0] V_RUN   = 6'b111100;
   localparam logic [5:0] V_HAZ   = 6'b001101;
   localparam logic [5:0] V_WAIT  = 6'b000000;
   localparam logic [5:0] V_FLUSH = 6'b111111;

   function automatic logic [5:0] ctl();
      return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_wen = 0; mem_wen = 0; wb_wen = 0;
      ex_is_load = 0; br_taken = 0; dmem_req = 0; dmem_ready = 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      int bad;
      idle();
      rst = 1'b0;
      #2;
      chk("reset_state", state, 2'b00);
      chk("reset_stall", stall_cycles, 0);
      chk("reset_flush", flush_count, 0);
      chk("reset_timeout", mem_timeout, 0);
      chk("reset_ctl_run", ctl(), V_RUN);
      step();
      rst = 1'b1;
      step();
      chk("idle_run", ctl(), V_RUN);
      chk("idle_state", state, 2'b00);

`ifndef FWD_EN
      // WB match stalls when forwarding is absent
      wb_rd = 3; wb_wen = 1; id_rs1 = 3; id_use_rs1 = 1;
      #1;
      chk("nofwd_wb_haz", ctl(), V_HAZ);
      chk("nofwd_sel1", fwd_rs1_sel, 0);
      step();
      chk("nofwd_state_haz", state, 2'b01);
      chk("nofwd_stall1", stall_cycles, 1);
      // hazard persists while the match remains
      step();
      chk("nofwd_hold_state", state, 2'b01);
      chk("nofwd_stall2", stall_cycles, 2);
      idle();
      id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0; ex_wen = 1;
      #1;
      chk("nofwd_x0_run", ctl(), V_RUN);
      step();
      chk("nofwd_x0_state", state, 2'b00);
      idle();
      mem_rd = 7; mem_wen = 1; id_rs2 = 7; id_use_rs2 = 1;
      #1;
      chk("nofwd_mem_rs2_haz", ctl(), V_HAZ);
      id_use_rs2 = 0;
      #1;
      chk("nofwd_unused_run", ctl(), V_RUN);
      idle();
      ex_rd = 9; ex_wen = 1; id_rs1 = 9; id_use_rs1 = 1;
      #1;
      chk("nofwd_ex_alu_haz", ctl(), V_HAZ);
      ex_wen = 0;
      #1;
      chk("nofwd_no_wen_run", ctl(), V_RUN);
      idle();
      step();
`else
      ex_rd = 5; ex_wen = 1; id_rs1 = 5; id_use_rs1 = 1;
      #1;
      chk("fwd_ex_sel1", fwd_rs1_sel, 1);
      chk("fwd_ex_run", ctl(), V_RUN);
      step();
      chk("fwd_ex_state", state, 2'b00);
      idle();
      ex_rd = 5; ex_wen = 1; ex_is_load = 1; id_rs2 = 5; id_use_rs2 = 1;
      #1;
      chk("fwd_load_haz", ctl(), V_HAZ);
      chk("fwd_load_sel_not1", fwd_rs2_sel, 0);
      step();
      chk("fwd_load_state", state, 2'b01);
      chk("fwd_load_stall", stall_cycles, 1);
      ex_wen = 0; ex_is_load = 0; mem_rd = 5; mem_wen = 1;
      #1;
      chk("fwd_mem_sel2", fwd_rs2_sel, 2);
      chk("fwd_mem_run", ctl(), V_RUN);
      step();
      chk("fwd_mem_state", state, 2'b00);
      idle();
      wb_rd = 4; wb_wen = 1; mem_rd = 4; mem_wen = 1; id_rs1 = 4; id_use_rs1 = 1;
      #1;
      chk("fwd_mem_over_wb", fwd_rs1_sel, 2);
      mem_wen = 0;
      #1;
      chk("fwd_wb_sel3", fwd_rs1_sel, 3);
      idle();
      id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0; ex_wen = 1;
      #1;
      chk("fwd_x0_sel0", fwd_rs1_sel, 0);
      idle();
      step();
`endif

      // branch beats a concurrent load-use match
      do_reset();
      ex_rd = 6; ex_wen = 1; ex_is_load = 1; id_rs1 = 6; id_use_rs1 = 1; br_taken = 1;
      #1;
      chk("flush_ctl", ctl(), V_FLUSH);
      step();
      chk("flush_state", state, 2'b11);
      chk("flush_count1", flush_count, 1);
      chk("flush_no_stall", stall_cycles, 0);
      idle();
      step();

      // 300-cycle memory wait with a pending branch
      do_reset();
      dmem_req = 1; dmem_ready = 0; br_taken = 1;
      bad = 0;
      for (int i = 1; i <= 300; i++) begin
         #1;
         if (ctl() !== V_WAIT) bad++;
         step();
         if (i == 254) chk("timeout_before_255", mem_timeout, 0);
         if (i == 255) chk("timeout_at_255", mem_timeout, 1);
      end
      chk("wait_freeze_all", bad, 0);
      chk("wait_state", state, 2'b10);
      chk("wait_stall300", stall_cycles, 300);
      chk("wait_no_flush", flush_count, 0);
      dmem_ready = 1; br_taken = 0;
      step();
      chk("timeout_sticky", mem_timeout, 1);
      chk("wait_exit_state", state, 2'b00);
      dmem_ready = 0;
      #1;
      chk("wait_after_timeout", ctl(), V_WAIT);

      // async reset in the middle of a wait
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("async_state", state, 2'b00);
      chk("async_stall", stall_cycles, 0);
      chk("async_timeout", mem_timeout, 0);
      chk("async_ctl_wait", ctl(), V_WAIT);
      idle();
      #1;
      rst = 1'b1;
      step();
      chk("post_rst_state", state, 2'b00);
      chk("post_rst_stall", stall_cycles, 0);
      chk("post_rst_ctl", ctl(), V_RUN);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
